// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and set-condition opcodes for the 16-bit pipeline
package pipe_pkg;

  localparam int DW = 16;
  localparam int RW = 3;

  localparam logic [4:0] OP_SEQ = 5'b11100;
  localparam logic [4:0] OP_SLT = 5'b11101;
  localparam logic [4:0] OP_SLE = 5'b11110;
  localparam logic [4:0] OP_SCO = 5'b11111;

  // All four set-condition opcodes share the 111xx prefix
  function automatic logic is_set_cond(input logic [4:0] opcode);
    return opcode[4:2] == 3'b111;
  endfunction

endpackage

// File: rtl/set_cond_resolve.sv
// rtl/set_cond_resolve.sv - turns ALU flags into a 0/1 result for SEQ/SLT/SLE/SCO
module set_cond_resolve #(
  parameter int DW = pipe_pkg::DW
) (
  input  logic [4:0]    opcode,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_z,
  input  logic          alu_ofl,
  input  logic          alu_cout,
  output logic [DW-1:0] result
);
  import pipe_pkg::*;

  // Signed less-than of A-B: sign bit corrected by overflow
  logic lt;
  assign lt = alu_out[DW-1] ^ alu_ofl;

  // Pick the flag-derived bit for set-condition ops, pass ALU value otherwise
  always_comb begin
    result = alu_out;
    if (is_set_cond(opcode)) begin
      case (opcode)
        OP_SEQ:  result = {{(DW-1){1'b0}}, alu_z};
        OP_SLT:  result = {{(DW-1){1'b0}}, lt & ~alu_z};
        OP_SLE:  result = {{(DW-1){1'b0}}, lt | alu_z};
        default: result = {{(DW-1){1'b0}}, alu_cout};
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with stall hold, flush bubble, error and stall count
module ex_mem_reg #(
  parameter int DW = pipe_pkg::DW,
  parameter int RW = pipe_pkg::RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [15:0]   in_instr,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_z,
  input  logic          alu_ofl,
  input  logic          alu_cout,
  input  logic [DW-1:0] in_st_data,
  input  logic [RW-1:0] in_wr_reg,
  input  logic          in_reg_wr,
  input  logic          in_mem_rd,
  input  logic          in_mem_wr,
  input  logic          in_halt,
  output logic          out_valid,
  output logic [DW-1:0] out_result,
  output logic [DW-1:0] out_st_data,
  output logic [RW-1:0] out_wr_reg,
  output logic          out_reg_wr,
  output logic          out_mem_rd,
  output logic          out_mem_wr,
  output logic          out_halt,
  output logic          fwd_en,
  output logic          err,
  output logic [15:0]   stall_cnt
);
  import pipe_pkg::*;

  logic          valid_q,     valid_d;
  logic [DW-1:0] result_q,    result_d;
  logic [DW-1:0] st_data_q,   st_data_d;
  logic [RW-1:0] wr_reg_q,    wr_reg_d;
  logic          reg_wr_q,    reg_wr_d;
  logic          mem_rd_q,    mem_rd_d;
  logic          mem_wr_q,    mem_wr_d;
  logic          halt_q,      halt_d;
  logic          err_q,       err_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  logic [DW-1:0] ex_result;
  logic          unused_instr_bits;

  // Only the major opcode matters here; the rest of the word is decoded upstream
  assign unused_instr_bits = ^in_instr[10:0];

  set_cond_resolve #(.DW(DW)) u_resolve (
    .opcode   (in_instr[15:11]),
    .alu_out  (alu_out),
    .alu_z    (alu_z),
    .alu_ofl  (alu_ofl),
    .alu_cout (alu_cout),
    .result   (ex_result)
  );

  // Next state: flush bubbles the control bits, stall holds and counts, else capture
  always_comb begin
    valid_d     = valid_q;
    result_d    = result_q;
    st_data_d   = st_data_q;
    wr_reg_d    = wr_reg_q;
    reg_wr_d    = reg_wr_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    halt_d      = halt_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      // Data fields keep their old values to avoid needless toggling
      valid_d  = 1'b0;
      reg_wr_d = 1'b0;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
      halt_d   = 1'b0;
    end else if (stall) begin
      if (valid_q && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end else begin
      valid_d   = in_valid;
      result_d  = ex_result;
      st_data_d = in_st_data;
      wr_reg_d  = in_wr_reg;
      reg_wr_d  = in_reg_wr & in_valid;
      mem_rd_d  = in_mem_rd & in_valid;
      mem_wr_d  = in_mem_wr & in_valid;
      halt_d    = in_halt & in_valid;
      // A real instruction that both loads and stores is a decode fault
      err_d     = err_q | (in_valid & in_mem_rd & in_mem_wr);
    end
  end

  // State register with synchronous reset overriding stall and flush
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      st_data_q   <= '0;
      wr_reg_q    <= '0;
      reg_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      halt_q      <= 1'b0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      result_q    <= result_d;
      st_data_q   <= st_data_d;
      wr_reg_q    <= wr_reg_d;
      reg_wr_q    <= reg_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      halt_q      <= halt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_result  = result_q;
  assign out_st_data = st_data_q;
  assign out_wr_reg  = wr_reg_q;
  assign out_reg_wr  = reg_wr_q;
  assign out_mem_rd  = mem_rd_q;
  assign out_mem_wr  = mem_wr_q;
  assign out_halt    = halt_q;
  assign err         = err_q;
  assign stall_cnt   = stall_cnt_q;

  // Load data only exists after the cache access, so it cannot be forwarded from here
  assign fwd_en = valid_q & reg_wr_q & ~mem_rd_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - self-checking bench for ex_mem_reg
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid;
  logic [15:0] in_instr, alu_out, in_st_data;
  logic        alu_z, alu_ofl, alu_cout;
  logic [2:0]  in_wr_reg;
  logic        in_reg_wr, in_mem_rd, in_mem_wr, in_halt;
  logic        out_valid, out_reg_wr, out_mem_rd, out_mem_wr, out_halt, fwd_en, err;
  logic [15:0] out_result, out_st_data, stall_cnt;
  logic [2:0]  out_wr_reg;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_instr(in_instr), .alu_out(alu_out), .alu_z(alu_z), .alu_ofl(alu_ofl),
    .alu_cout(alu_cout), .in_st_data(in_st_data), .in_wr_reg(in_wr_reg),
    .in_reg_wr(in_reg_wr), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .in_halt(in_halt), .out_valid(out_valid), .out_result(out_result),
    .out_st_data(out_st_data), .out_wr_reg(out_wr_reg), .out_reg_wr(out_reg_wr),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_halt(out_halt),
    .fwd_en(fwd_en), .err(err), .stall_cnt(stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_valid, m_reg_wr, m_mem_rd, m_mem_wr, m_halt, m_err;
  logic [15:0] m_result, m_st;
  logic [2:0]  m_wr_reg;
  int          m_cnt;
  logic [15:0] want_res;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] alu;
    logic        z, ofl, cout;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock edge: the model applies the rules to the inputs present at the edge
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_result = 0; m_st = 0; m_wr_reg = 0; m_reg_wr = 0;
      m_mem_rd = 0; m_mem_wr = 0; m_halt = 0; m_err = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0; m_reg_wr = 0; m_mem_rd = 0; m_mem_wr = 0; m_halt = 0;
    end else if (stall) begin
      if (m_valid && m_cnt < 65535) m_cnt++;
    end else begin
      m_valid  = in_valid;
      m_result = want_res;
      m_st     = in_st_data;
      m_wr_reg = in_wr_reg;
      m_reg_wr = in_valid && in_reg_wr;
      m_mem_rd = in_valid && in_mem_rd;
      m_mem_wr = in_valid && in_mem_wr;
      m_halt   = in_valid && in_halt;
      if (in_valid && in_mem_rd && in_mem_wr) m_err = 1;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},   out_valid,   m_valid);
    chk({tag, ".result"},  out_result,  m_result);
    chk({tag, ".st_data"}, out_st_data, m_st);
    chk({tag, ".wr_reg"},  out_wr_reg,  m_wr_reg);
    chk({tag, ".reg_wr"},  out_reg_wr,  m_reg_wr);
    chk({tag, ".mem_rd"},  out_mem_rd,  m_mem_rd);
    chk({tag, ".mem_wr"},  out_mem_wr,  m_mem_wr);
    chk({tag, ".halt"},    out_halt,    m_halt);
    chk({tag, ".fwd_en"},  fwd_en,      m_valid && m_reg_wr && !m_mem_rd);
    chk({tag, ".err"},     err,         m_err);
    chk({tag, ".cnt"},     stall_cnt,   m_cnt[15:0]);
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; flush = 0; in_valid = 0; in_instr = 16'h0000;
    alu_out = 0; alu_z = 0; alu_ofl = 0; alu_cout = 0; in_st_data = 0;
    in_wr_reg = 0; in_reg_wr = 0; in_mem_rd = 0; in_mem_wr = 0; in_halt = 0;
    want_res = 0;
  endtask

  // Plain ALU op (non set-condition): result passes straight through
  task automatic drive_add(input logic [15:0] v, input logic [2:0] rd, input logic rw);
    in_valid = 1; in_instr = 16'hD800; alu_out = v; want_res = v;
    alu_z = 0; alu_ofl = 0; alu_cout = 0; in_wr_reg = rd; in_reg_wr = rw;
    in_mem_rd = 0; in_mem_wr = 0; in_halt = 0; in_st_data = v ^ 16'hA5A5;
  endtask

  // Build ALU outputs from real operands; expected result from plain comparisons
  task automatic drive_random_op();
    logic [15:0] a, b;
    logic [16:0] s;
    int kind;
    a = 16'($urandom); b = 16'($urandom);
    if ($urandom_range(0, 3) == 0) b = a;
    kind = $urandom_range(0, 4);
    case (kind)
      0, 1, 2: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        alu_out = s[15:0]; alu_cout = s[16]; alu_z = (s[15:0] == 0);
        alu_ofl = (a[15] != b[15]) && (s[15] != a[15]);
        if (kind == 0) begin in_instr = 16'hE000; want_res = {15'b0, a == b}; end
        else if (kind == 1) begin in_instr = 16'hE800; want_res = {15'b0, $signed(a) < $signed(b)}; end
        else begin in_instr = 16'hF000; want_res = {15'b0, $signed(a) <= $signed(b)}; end
      end
      3: begin
        s = {1'b0, a} + {1'b0, b};
        alu_out = s[15:0]; alu_cout = s[16]; alu_z = (s[15:0] == 0);
        alu_ofl = (a[15] == b[15]) && (s[15] != a[15]);
        in_instr = 16'hF800; want_res = {15'b0, s[16]};
      end
      default: begin
        in_instr = {5'($urandom_range(0, 27)), 11'($urandom)};
        alu_out = a; want_res = a;
        alu_z = 1'($urandom); alu_ofl = 1'($urandom); alu_cout = 1'($urandom);
      end
    endcase
    in_instr[10:0] = 11'($urandom);
  endtask

  initial begin
    vecs[0]  = '{16'hE800, 16'h8003, 0, 0, 0, 16'h0001};
    vecs[1]  = '{16'hE800, 16'h7FFF, 0, 1, 0, 16'h0001};
    vecs[2]  = '{16'hE800, 16'h0000, 1, 0, 0, 16'h0000};
    vecs[3]  = '{16'hE000, 16'h0000, 1, 0, 0, 16'h0001};
    vecs[4]  = '{16'hE000, 16'h0005, 0, 0, 1, 16'h0000};
    vecs[5]  = '{16'hF000, 16'h0000, 1, 0, 0, 16'h0001};
    vecs[6]  = '{16'hF000, 16'h0003, 0, 0, 1, 16'h0000};
    vecs[7]  = '{16'hF800, 16'h0000, 1, 0, 1, 16'h0001};
    vecs[8]  = '{16'hF800, 16'hFFFF, 0, 0, 0, 16'h0000};
    vecs[9]  = '{16'hD800, 16'h1234, 0, 0, 0, 16'h1234};
    vecs[10] = '{16'hD800, 16'hFFFE, 1, 1, 1, 16'hFFFE};

    idle_inputs();
    m_cnt = 0;

    // Reset for two cycles: all outputs zero
    rst = 1;
    step(); step();
    chk("rst.valid", out_valid, 0);
    chk("rst.result", out_result, 0);
    chk("rst.err", err, 0);
    chk("rst.cnt", stall_cnt, 0);
    check_all("rst");
    rst = 0;

    // Idle bubbles, and a stall over a bubble does not count
    for (int i = 0; i < 3; i++) begin step(); check_all("idle"); end
    chk("idle.valid", out_valid, 0);
    stall = 1; step(); step(); stall = 0;
    chk("idle_stall.cnt", stall_cnt, 0);

    // Result-select table
    for (int i = 0; i < 11; i++) begin
      in_valid = 1; in_instr = vecs[i].instr; alu_out = vecs[i].alu;
      alu_z = vecs[i].z; alu_ofl = vecs[i].ofl; alu_cout = vecs[i].cout;
      in_reg_wr = 1; in_wr_reg = 3'(i); want_res = vecs[i].exp;
      step();
      chk($sformatf("vec%0d.result", i), out_result, vecs[i].exp);
      chk($sformatf("vec%0d.valid", i), out_valid, 1);
    end

    // Stall hold and count
    drive_add(16'h4321, 3'd5, 1);
    step();
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      drive_add(16'(16'h1000 + i), 3'd2, 0);
      step();
      chk("stall.result", out_result, 16'h4321);
      chk("stall.fwd", fwd_en, 1);
      check_all("stall");
    end
    chk("stall.cnt5", stall_cnt, 5);
    stall = 0; drive_add(16'h5555, 3'd1, 1);
    step();
    chk("unstall.result", out_result, 16'h5555);

    // Flush beats stall on the same edge; counter unchanged, data held
    stall = 1; flush = 1;
    step();
    chk("fs.valid", out_valid, 0);
    chk("fs.reg_wr", out_reg_wr, 0);
    chk("fs.fwd", fwd_en, 0);
    chk("fs.cnt", stall_cnt, 5);
    chk("fs.result_hold", out_result, 16'h5555);
    stall = 0; flush = 0;

    // Control error is sticky across flushes
    drive_add(16'h0100, 3'd3, 0);
    in_mem_rd = 1; in_mem_wr = 1;
    step();
    chk("err.set", err, 1);
    flush = 1;
    for (int i = 0; i < 10; i++) begin step(); chk("err.flush", err, 1); end
    flush = 0;

    // Valid load is not forwardable
    drive_add(16'h0200, 3'd4, 1);
    in_mem_rd = 1;
    step();
    chk("load.fwd", fwd_en, 0);
    chk("load.mem_rd", out_mem_rd, 1);
    check_all("load");

    // Stalled cycle cannot set err
    rst = 1; step(); rst = 0;
    drive_add(16'h0300, 3'd1, 0); step();
    stall = 1; in_mem_rd = 1; in_mem_wr = 1; step();
    chk("err.stall_noset", err, 0);
    stall = 0; in_mem_rd = 0; in_mem_wr = 0;

    // Halt held under stall until the next load
    drive_add(16'h0400, 3'd0, 0); in_halt = 1; step();
    stall = 1; in_halt = 0;
    for (int i = 0; i < 3; i++) begin step(); chk("halt.hold", out_halt, 1); end
    stall = 0; step();
    chk("halt.drop", out_halt, 0);

    // Reset in the middle of a stall
    stall = 1; step(); step();
    rst = 1; step();
    chk("rst_stall.valid", out_valid, 0);
    chk("rst_stall.cnt", stall_cnt, 0);
    check_all("rst_stall");
    rst = 0; stall = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive_random_op();
      in_valid   = ($urandom_range(0, 4) != 0);
      stall      = ($urandom_range(0, 4) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      rst        = ($urandom_range(0, 59) == 0);
      in_st_data = 16'($urandom);
      in_wr_reg  = 3'($urandom);
      in_reg_wr  = 1'($urandom);
      in_mem_rd  = ($urandom_range(0, 3) == 0);
      in_mem_wr  = ($urandom_range(0, 3) == 0) && ($urandom_range(0, 7) == 0 || !in_mem_rd);
      in_halt    = ($urandom_range(0, 15) == 0);
      step();
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the 16-bit pipelined RISC core. It consumes the ALU result and flags from the execute stage and feeds the memory/cache stage and the EX→EX forwarding path.
- It resolves set-condition instructions (SEQ/SLT/SLE/SCO, opcode 111xx) from the ALU flags into a 0/1 result before registering.
- It holds on cache stall, bubbles on flush, and keeps a sticky control-error flag and a saturating stall counter.

Parameters:
- DW, 16, datapath width.
- RW, 3, register-index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  memory stage busy (cache miss); hold all state
- flush  in  1  squash; load a bubble
- in_valid  in  1  EX holds a real instruction
- in_instr  in  16  instruction word in EX
- alu_out  in  DW  ALU Out
- alu_z  in  1  ALU zero flag
- alu_ofl  in  1  ALU signed-overflow flag
- alu_cout  in  1  ALU carry-out
- in_st_data  in  DW  Rt value for stores
- in_wr_reg  in  RW  destination register
- in_reg_wr  in  1  register write enable
- in_mem_rd  in  1  load
- in_mem_wr  in  1  store
- in_halt  in  1  HALT in EX
- out_valid  out  1  MEM-side instruction valid
- out_result  out  DW  registered EX result / memory address
- out_st_data  out  DW  registered store data
- out_wr_reg  out  RW  registered destination register
- out_reg_wr  out  1  registered write enable, gated by valid
- out_mem_rd  out  1  registered load, gated by valid
- out_mem_wr  out  1  registered store, gated by valid
- out_halt  out  1  registered halt, gated by valid
- fwd_en  out  1  out_result usable for forwarding
- err  out  1  sticky control error
- stall_cnt  out  16  saturating count of stalled cycles

Behaviour:
- Reset: every output is 0, including err and stall_cnt.
- Update priority each rising clk edge: rst > flush > stall > load.
- flush: out_valid, out_reg_wr, out_mem_rd, out_mem_wr and out_halt go to 0. Data fields are don't-care but must hold their old values (no toggle). flush wins over a simultaneous stall.
- stall (and no flush): all pipeline fields hold.
- load (neither stall nor flush): capture the inputs.
- Valid gating: out_reg_wr, out_mem_rd, out_mem_wr and out_halt equal the captured flag AND in_valid. in_valid=0 therefore loads a bubble.
- Result select, combinational before the register, keyed on in_instr[15:11]:
  - 11100 SEQ: result = {15'b0, alu_z}.
  - 11101 SLT: result = {15'b0, (alu_out[15]^alu_ofl) & ~alu_z}.
  - 11110 SLE: result = {15'b0, (alu_out[15]^alu_ofl) | alu_z}.
  - 11111 SCO: result = {15'b0, alu_cout}.
  - Any other opcode: result = alu_out unchanged.
  - The ALU side presents A+~B+1 with sign=1 for SEQ/SLT/SLE, and A+B for SCO.
- Latency: exactly 1 cycle from capture to output. No combinational path from any input to any output.
- fwd_en = out_valid & out_reg_wr & ~out_mem_rd. A load result is not forwardable from this stage.
- err:
  - Set on a load cycle when in_valid & in_mem_rd & in_mem_wr.
  - Sticky until rst. flush and stall do not clear it.
  - A stalled or flushed cycle cannot set it.
- stall_cnt:
  - +1 on each edge with stall=1 & flush=0 & out_valid=1.
  - Saturates at 16'hFFFF and never wraps.
  - Cleared only by rst.
- Reset mid-stall: rst overrides and all state clears the same cycle.
- A halt held under stall keeps out_halt=1 until the stall drops and the next load.

Decomposition:
- Shared package pipe_pkg: DW and RW; opcode constants OP_SEQ=5'b11100, OP_SLT=5'b11101, OP_SLE=5'b11110, OP_SCO=5'b11111.
- One natural sub-module: set_cond_resolve. It is combinational (instr[15:11], alu_out, flags → result) and is reusable by the branch unit.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles → all outputs 0. in_valid=0 for 3 cycles → out_valid=0 and stall_cnt=0.
2. SLT signed:
   - instr=16'hE800, alu_out=16'h8003, ofl=0, z=0 → out_result=16'h0001 next cycle.
   - alu_out=16'h7FFF with ofl=1 → out_result=16'h0001.
   - alu_out=16'h0000 with z=1 → out_result=16'h0000.
3. SLE/SEQ/SCO:
   - SEQ with z=1 → 1.
   - SLE with z=1 → 1.
   - SCO with cout=1 and alu_out=16'h0000 → 1.
   - ADD 16'hD800 with alu_out=16'h1234 → 16'h1234 passthrough.
4. Stall hold and count: load an ADD with reg_wr=1, then stall=1 for 5 cycles while the inputs change → outputs frozen, fwd_en=1, stall_cnt=5. Drop stall → new instruction appears 1 cycle later.
5. Flush vs stall: stall=1 and flush=1 on the same edge → out_valid=0, out_reg_wr=0, fwd_en=0, stall_cnt unchanged.
6. Error and load forwarding:
   - in_valid=1 with mem_rd=mem_wr=1 → err=1 and it stays 1 across 10 cycles of flush.
   - A valid load with reg_wr=1 → fwd_en=0.
   - rst → err=0.
